dmem_line_ctrl: RTL and testbench

DMEM_LINE_CTRL -- requirements
Module: dmem_line_ctrl

---
 rtl/dmem_line_ctrl.sv | 95 +++++++++
 tb/tb_dmem_line_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory with a fixed access latency, serving one
// 256-bit read or write per request and pulsing ack_o when it completes.
module dmem_line_ctrl #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Counter starts at LATENCY-1 so the commit lands exactly LATENCY edges after acceptance.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [255:0]            wdata_q;
  logic                    write_q;
  logic                    ack_q;
  logic [255:0]            rdata_q;
  logic [255:0]            mem_q [2**DEPTH_LOG2];
  logic                    commit_s;
  logic                    unused_addr_s;

  assign commit_s      = (state_q == WAIT) && (cnt_q == 8'd0);
  assign unused_addr_s = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};
  assign ack_o         = ack_q;
  assign data_o        = rdata_q;

  // Array is deliberately left out of reset; only a completing write touches it.
  always_ff @(posedge clk_i) begin
    if (commit_s && write_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Request FSM: capture, count down, then pulse ack with the registered read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 256'd0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 256'd0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        // ACK always leaves; a request waiting on that edge is taken so streams run without a bubble.
        IDLE, ACK: begin
          if (enable_i) begin
            addr_q  <= addr_i[DEPTH_LOG2+4:5];
            wdata_q <= data_i;
            write_q <= write_i;
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            if (!write_q) begin
              rdata_q <= mem_q[addr_q];
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed bench for dmem_line_ctrl: a table of line transactions followed by
// hand-written sequences for back-to-back, dropped enable and mid-wait reset.
module tb_dmem_line_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         write;
  logic [31:0]  addr;
  logic [255:0] data;
  logic         ack;
  logic [255:0] dout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[8];

  dmem_line_ctrl #(.LATENCY(10), .DEPTH_LOG2(9)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .enable_i(enable),
    .write_i (write),
    .addr_i  (addr),
    .data_i  (data),
    .ack_o   (ack),
    .data_o  (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one request, hold enable until ack is seen, return edges from acceptance to ack.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [255:0] d, output int lat);
    enable = 1'b1; write = wr; addr = a; data = d;
    @(posedge clk); #1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = n;
        break;
      end
    end
    enable = 1'b0; write = 1'b0;
  endtask

  task automatic watch_no_ack(input int cycles, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
  endtask

  logic [255:0] last_rd;
  logic [255:0] prior;
  int           lat;
  int           lat2;
  logic         seen;
  logic         bad_ack;
  logic         bad_data;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0040, {32{8'hA5}},        256'd0};
    vecs[1] = '{1'b0, 32'h0000_0040, 256'd0,             {32{8'hA5}}};
    vecs[2] = '{1'b1, 32'h0000_4020, {32{8'h3C}},        256'd0};
    vecs[3] = '{1'b0, 32'h0000_0020, 256'd0,             {32{8'h3C}}};
    vecs[4] = '{1'b1, 32'h0000_0200, {8{32'hDEADBEEF}},  256'd0};
    vecs[5] = '{1'b0, 32'h0000_0200, 256'd0,             {8{32'hDEADBEEF}}};
    vecs[6] = '{1'b1, 32'h0000_3FE0, {16{16'h9669}},     256'd0};
    vecs[7] = '{1'b0, 32'h0000_3FFF, 256'd0,             {16{16'h9669}}};

    rst = 1'b1; enable = 1'b0; write = 1'b0; addr = 32'd0; data = 256'd0;
    #2;
    chk("reset_ack", {255'd0, ack}, 256'd0);
    chk("reset_data", dout, 256'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    bad_ack = 1'b0; bad_data = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) bad_ack = 1'b1;
      if (dout !== 256'd0) bad_data = 1'b1;
    end
    chk("idle_ack", {255'd0, bad_ack}, 256'd0);
    chk("idle_data", {255'd0, bad_data}, 256'd0);

    last_rd = 256'd0;
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd10);
      if (vecs[i].wr) chk($sformatf("vec%0d_hold", i), dout, last_rd);
      else begin
        chk($sformatf("vec%0d_rdata", i), dout, vecs[i].exp);
        last_rd = vecs[i].exp;
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ack_width", i), {255'd0, ack}, 256'd0);
    end

    // Back-to-back: write 0x100, read 0x200 presented during the write's ack cycle.
    enable = 1'b1; write = 1'b1; addr = 32'h100; data = {4{64'hCAFE_F00D_1234_5678}};
    @(posedge clk); #1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat = n; break; end
    end
    chk("b2b_first_latency", 256'(lat), 256'd10);
    write = 1'b0; addr = 32'h200;
    @(posedge clk); #1;
    enable = 1'b0;
    chk("b2b_first_width", {255'd0, ack}, 256'd0);
    lat2 = 0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat2 = n; break; end
    end
    chk("b2b_spacing", 256'(lat2), 256'd11);
    chk("b2b_rdata", dout, {8{32'hDEADBEEF}});
    @(posedge clk); #1;
    chk("b2b_second_width", {255'd0, ack}, 256'd0);
    watch_no_ack(20, seen);
    chk("b2b_no_third", {255'd0, seen}, 256'd0);

    // Enable dropped right after acceptance; write must still complete.
    enable = 1'b1; write = 1'b1; addr = 32'h60; data = {32{8'hE7}};
    @(posedge clk); #1;
    enable = 1'b0; write = 1'b0; addr = 32'h0; data = 256'd0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat = n; break; end
    end
    chk("drop_latency", 256'(lat), 256'd10);
    do_req(1'b0, 32'h60, 256'd0, lat);
    chk("drop_rdata", dout, {32{8'hE7}});

    // Reset during WAIT discards the pending write.
    prior = {8{32'h5555_AAAA}};
    do_req(1'b1, 32'h300, prior, lat);
    chk("rst_pre_latency", 256'(lat), 256'd10);
    enable = 1'b1; write = 1'b1; addr = 32'h300; data = 256'd1;
    @(posedge clk); #1;
    enable = 1'b0; write = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ack", {255'd0, ack}, 256'd0);
    chk("rst_mid_data", dout, 256'd0);
    @(posedge clk); #1 rst = 1'b0;
    watch_no_ack(20, seen);
    chk("rst_no_ack", {255'd0, seen}, 256'd0);
    do_req(1'b0, 32'h300, 256'd0, lat);
    chk("rst_read_latency", 256'(lat), 256'd10);
    chk("rst_read_prior", dout, prior);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
